// File: rtl/load_store_unit.sv
// RV32I load/store initiator on a word-addressed memory: byte/halfword extraction
// for loads and read-modify-write for partial stores, one request at a time.
module load_store_unit #(
  parameter int unsigned MEMORY_BYTES = 4096
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_address,
  input  logic [31:0] req_store_data,
  output logic        resp_valid,
  output logic [1:0]  resp_error,
  output logic [31:0] load_data,
  output logic        read_enable,
  output logic [31:0] read_address,
  input  logic [31:0] read_value,
  output logic        write_enable,
  output logic [31:0] write_address,
  output logic [31:0] write_value
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_READ    = 3'd1;
  localparam logic [2:0] S_CAPTURE = 3'd2;
  localparam logic [2:0] S_WRITE   = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;
  localparam logic [2:0] S_ERROR   = 3'd5;

  localparam logic [1:0] ERR_MISALIGNED = 2'b01;
  localparam logic [1:0] ERR_FAULT      = 2'b10;

  logic [2:0]  state;
  logic        op_store;
  logic [2:0]  op_funct3;
  logic [31:0] op_address;
  logic [15:0] op_store_low;
  logic [31:0] write_buffer;
  logic [31:0] load_result;
  logic [1:0]  error_code;

  logic        funct3_legal;
  logic        access_fault;
  logic        misaligned;
  logic [31:0] lane_shifted;
  logic [31:0] extracted;
  logic [31:0] merged;

  always_comb begin
    funct3_legal = 1'b0;
    if (req_is_store) begin
      funct3_legal = req_funct3 inside {3'b000, 3'b001, 3'b010};
    end else begin
      funct3_legal = req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    end
    access_fault = !funct3_legal || (req_address >= MEMORY_BYTES);
    misaligned   = ((req_funct3[1:0] == 2'b01) && req_address[0]) ||
                   ((req_funct3[1:0] == 2'b10) && (req_address[1:0] != 2'b00));
  end

  // Lane select is a right shift by 8*addr[1:0]; halfwords are already 2-byte aligned.
  always_comb begin
    lane_shifted = read_value >> {op_address[1:0], 3'b000};
    case (op_funct3)
      3'b000:  extracted = {{24{lane_shifted[7]}}, lane_shifted[7:0]};
      3'b100:  extracted = {24'h000000, lane_shifted[7:0]};
      3'b001:  extracted = {{16{lane_shifted[15]}}, lane_shifted[15:0]};
      3'b101:  extracted = {16'h0000, lane_shifted[15:0]};
      default: extracted = read_value;
    endcase
  end

  always_comb begin
    merged = read_value;
    if (op_funct3[1:0] == 2'b00) begin
      merged[{op_address[1:0], 3'b000} +: 8] = op_store_low[7:0];
    end else begin
      merged[{op_address[1], 4'b0000} +: 16] = op_store_low;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      op_store     <= 1'b0;
      op_funct3    <= '0;
      op_address   <= '0;
      op_store_low <= '0;
      write_buffer <= '0;
      load_result  <= '0;
      error_code   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            op_store     <= req_is_store;
            op_funct3    <= req_funct3;
            op_address   <= req_address;
            op_store_low <= req_store_data[15:0];
            if (access_fault) begin
              error_code <= ERR_FAULT;
              state      <= S_ERROR;
            end else if (misaligned) begin
              error_code <= ERR_MISALIGNED;
              state      <= S_ERROR;
            end else if (req_is_store && (req_funct3 == 3'b010)) begin
              write_buffer <= req_store_data;
              state        <= S_WRITE;
            end else begin
              state <= S_READ;
            end
          end
        end
        S_READ:    state <= S_CAPTURE;
        S_CAPTURE: begin
          if (op_store) begin
            write_buffer <= merged;
            state        <= S_WRITE;
          end else begin
            load_result <= extracted;
            state       <= S_DONE;
          end
        end
        S_WRITE:   state <= S_DONE;
        S_DONE:    state <= S_IDLE;
        S_ERROR:   state <= S_IDLE;
        default:   state <= S_IDLE;
      endcase
    end
  end

  assign req_ready     = (state == S_IDLE);
  assign read_enable   = (state == S_READ);
  assign write_enable  = (state == S_WRITE);
  assign resp_valid    = (state == S_DONE) || (state == S_ERROR);
  assign resp_error    = (state == S_ERROR) ? error_code : 2'b00;
  assign load_data     = load_result;
  assign read_address  = {op_address[31:2], 2'b00};
  assign write_address = {op_address[31:2], 2'b00};
  assign write_value   = write_buffer;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: vector table driven through a scoreboard,
// a held-valid LW/SW stream against a reference word model, and a mid-operation reset.
module tb_load_store_unit;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_is_store = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_address = '0;
  logic [31:0] req_store_data = '0;
  logic        resp_valid;
  logic [1:0]  resp_error;
  logic [31:0] load_data;
  logic        read_enable;
  logic [31:0] read_address;
  logic [31:0] read_value = '0;
  logic        write_enable;
  logic [31:0] write_address;
  logic [31:0] write_value;

  load_store_unit #(.MEMORY_BYTES(4096)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_funct3(req_funct3), .req_address(req_address), .req_store_data(req_store_data),
    .resp_valid(resp_valid), .resp_error(resp_error), .load_data(load_data),
    .read_enable(read_enable), .read_address(read_address), .read_value(read_value),
    .write_enable(write_enable), .write_address(write_address), .write_value(write_value)
  );

  always #5 clock = ~clock;

  logic [31:0] mem [1024];
  always @(posedge clock) begin
    if (read_enable) read_value <= mem[read_address[11:2]];
    if (write_enable) mem[write_address[11:2]] = write_value;
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [1:0]  err;
    logic [31:0] ld;
    int          lat;
    int          rd;
    int          wr;
    int          acc;
  } exp_t;
  exp_t sb[$];

  int rd_cnt = 0;
  int wr_cnt = 0;

  always @(posedge clock) begin
    exp_t e;
    #2;
    if (!reset_n) begin
      rd_cnt = 0;
      wr_cnt = 0;
    end else begin
      if (read_enable && write_enable) check("enables_exclusive", 32'd1, 32'd0);
      if (read_enable) rd_cnt++;
      if (write_enable) wr_cnt++;
      if (sb.size() > 0) check("ready_low_busy", {31'd0, req_ready}, 32'd0);
      if (resp_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_resp", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("resp_error", {30'd0, resp_error}, {30'd0, e.err});
          check("load_data", load_data, e.ld);
          check("latency", cyc - e.acc + 1, e.lat);
          check("read_pulses", rd_cnt, e.rd);
          check("write_pulses", wr_cnt, e.wr);
        end
        rd_cnt = 0;
        wr_cnt = 0;
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (!req_ready) check("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] data, input logic [1:0] err, input logic [31:0] ld,
                        input int lat, input int rd, input int wr, input logic hold);
    exp_t e;
    @(negedge clock);
    req_is_store   = st;
    req_funct3     = f3;
    req_address    = addr;
    req_store_data = data;
    req_valid      = 1'b1;
    wait_ready();
    e.err = err; e.ld = ld; e.lat = lat; e.rd = rd; e.wr = wr; e.acc = cyc + 1;
    sb.push_back(e);
    @(posedge clock);
    #1;
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sb.size() > 0 && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (sb.size() > 0) begin
      check("response_timeout", sb.size(), 32'd0);
      sb.delete();
    end
  endtask

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  err;
    logic [31:0] ld;
    int          lat;
    int          rd;
    int          wr;
    logic [31:0] mem10;
  } vec_t;
  vec_t vecs [20];

  logic [31:0] ref_w [3];
  logic [31:0] last_ld;
  logic [31:0] d;
  int widx;

  initial begin
    vecs[0]  = '{1'b0, 3'b000, 32'h011, 32'h0, 2'b00, 32'hFFFFFFAA, 3, 1, 0, 32'h8899AABB};
    vecs[1]  = '{1'b0, 3'b100, 32'h013, 32'h0, 2'b00, 32'h00000088, 3, 1, 0, 32'h8899AABB};
    vecs[2]  = '{1'b0, 3'b001, 32'h012, 32'h0, 2'b00, 32'hFFFF8899, 3, 1, 0, 32'h8899AABB};
    vecs[3]  = '{1'b0, 3'b101, 32'h010, 32'h0, 2'b00, 32'h0000AABB, 3, 1, 0, 32'h8899AABB};
    vecs[4]  = '{1'b0, 3'b010, 32'h010, 32'h0, 2'b00, 32'h8899AABB, 3, 1, 0, 32'h8899AABB};
    vecs[5]  = '{1'b1, 3'b000, 32'h012, 32'h123456CC, 2'b00, 32'h8899AABB, 4, 1, 1, 32'h88CCAABB};
    vecs[6]  = '{1'b1, 3'b001, 32'h010, 32'h00001111, 2'b00, 32'h8899AABB, 4, 1, 1, 32'h88CC1111};
    vecs[7]  = '{1'b1, 3'b010, 32'h010, 32'hDEADBEEF, 2'b00, 32'h8899AABB, 2, 0, 1, 32'hDEADBEEF};
    vecs[8]  = '{1'b0, 3'b010, 32'h012, 32'h0, 2'b01, 32'h8899AABB, 1, 0, 0, 32'hDEADBEEF};
    vecs[9]  = '{1'b1, 3'b001, 32'h011, 32'h5555, 2'b01, 32'h8899AABB, 1, 0, 0, 32'hDEADBEEF};
    vecs[10] = '{1'b0, 3'b000, 32'h1000, 32'h0, 2'b10, 32'h8899AABB, 1, 0, 0, 32'hDEADBEEF};
    vecs[11] = '{1'b0, 3'b011, 32'h010, 32'h0, 2'b10, 32'h8899AABB, 1, 0, 0, 32'hDEADBEEF};
    vecs[12] = '{1'b1, 3'b100, 32'h010, 32'h0, 2'b10, 32'h8899AABB, 1, 0, 0, 32'hDEADBEEF};
    vecs[13] = '{1'b1, 3'b010, 32'h1001, 32'h0, 2'b10, 32'h8899AABB, 1, 0, 0, 32'hDEADBEEF};
    vecs[14] = '{1'b0, 3'b010, 32'h010, 32'h0, 2'b00, 32'hDEADBEEF, 3, 1, 0, 32'hDEADBEEF};
    vecs[15] = '{1'b1, 3'b000, 32'h013, 32'h00000077, 2'b00, 32'hDEADBEEF, 4, 1, 1, 32'h77ADBEEF};
    vecs[16] = '{1'b0, 3'b001, 32'hFFE, 32'h0, 2'b00, 32'h00000123, 3, 1, 0, 32'h77ADBEEF};
    vecs[17] = '{1'b0, 3'b000, 32'hFFF, 32'h0, 2'b00, 32'h00000001, 3, 1, 0, 32'h77ADBEEF};
    vecs[18] = '{1'b0, 3'b100, 32'hFFC, 32'h0, 2'b00, 32'h00000067, 3, 1, 0, 32'h77ADBEEF};
    vecs[19] = '{1'b0, 3'b110, 32'h010, 32'h0, 2'b10, 32'h00000067, 1, 0, 0, 32'h77ADBEEF};

    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[4]    = 32'h8899AABB;
    mem[1023] = 32'h01234567;

    repeat (3) @(negedge clock);
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_error", {30'd0, resp_error}, 32'd0);
    check("rst_load_data", load_data, 32'd0);
    check("rst_enables", {30'd0, read_enable, write_enable}, 32'd0);
    check("rst_read_address", read_address, 32'd0);
    check("rst_write_address", write_address, 32'd0);
    check("rst_write_value", write_value, 32'd0);
    reset_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      do_req(vecs[i].st, vecs[i].f3, vecs[i].addr, vecs[i].data, vecs[i].err, vecs[i].ld,
             vecs[i].lat, vecs[i].rd, vecs[i].wr, 1'b0);
      wait_idle();
      check($sformatf("mem10_vec%0d", i), mem[4], vecs[i].mem10);
    end

    // Held-valid alternating SW/LW stream against a reference copy of words 0x100..0x108.
    for (int i = 0; i < 3; i++) begin
      ref_w[i]   = 32'h1000_0000 + i;
      mem[64+i]  = ref_w[i];
    end
    last_ld = 32'h00000067;
    for (int i = 0; i < 12; i++) begin
      if (i % 2 == 0) begin
        widx = (i / 2) % 3;
        d = $urandom;
        ref_w[widx] = d;
        do_req(1'b1, 3'b010, 32'h100 + 4 * widx, d, 2'b00, last_ld, 2, 0, 1, i != 11);
      end else begin
        widx = (i / 2 + 1) % 3;
        last_ld = ref_w[widx];
        do_req(1'b0, 3'b010, 32'h100 + 4 * widx, 32'h0, 2'b00, last_ld, 3, 1, 0, i != 11);
      end
    end
    req_valid = 1'b0;
    wait_idle();
    for (int i = 0; i < 3; i++) check($sformatf("stream_mem%0d", i), mem[64+i], ref_w[i]);

    // Reset asserted while an SB sits in CAPTURE.
    @(negedge clock);
    req_is_store = 1'b1; req_funct3 = 3'b000; req_address = 32'h10; req_store_data = 32'h55;
    req_valid = 1'b1;
    wait_ready();
    @(posedge clock);
    #1 req_valid = 1'b0;
    @(posedge clock);
    #3 reset_n = 1'b0;
    #1;
    check("abort_enables", {30'd0, read_enable, write_enable}, 32'd0);
    check("abort_ready", {31'd0, req_ready}, 32'd1);
    check("abort_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("abort_load_data", load_data, 32'd0);
    repeat (2) @(negedge clock);
    check("abort_mem10", mem[4], 32'h77ADBEEF);
    reset_n = 1'b1;
    do_req(1'b0, 3'b010, 32'h010, 32'h0, 2'b00, 32'h77ADBEEF, 3, 1, 0, 1'b0);
    wait_idle();
    repeat (3) @(negedge clock);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
